vec_mean_stream: RTL and testbench
==================================

# vec_mean_stream

Streaming, parametrised mean unit for the normalisation path. Accepts a vector of `VEC_LEN` signed fixed-point elements as `VEC_LEN/LANES` beats of `LANES` elements over a valid/ready handshake. Accumulates the beats at full precision and returns the element mean, plus optionally the mean square for RMSNorm, through a second valid/ready handshake. It generalises the combinational single-beat vector mean to multi-beat vectors with backpressure, length checking and an optional second statistic.

## Interface
Parameters:
- `LANES`, default `ARR_WIDTH`: elements per input beat.
- `VEC_LEN`, default `4*ARR_WIDTH`: elements per vector.
  - Must be a power of two and a multiple of `LANES`.
  - `BEATS = VEC_LEN/LANES`.
- `DATA_W`, default `FXP_N`: element and result width, signed two's complement.
- `FRAC_W`, default `FXP_R`: fractional bits (Q format shared by input and output).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: unit can accept a beat.
- `in_data` in `[LANES-1:0][DATA_W-1:0]`: signed input elements.
- `in_last` in 1: producer marks the final beat of a vector.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `mean_out` out `DATA_W`: signed mean.
- `msq_out` out `DATA_W`: mean of squares. Present only with `VEC_MEAN_MSQ_EN`.
- `len_err` out 1: one-cycle pulse on a framing mismatch.

## Operation
- States:
  - ACCUM: `in_ready=1`.
  - HOLD: `out_valid=1`, `in_ready=0`.
- Beat accepted when `in_valid && in_ready`:
  - The beat sum (adder tree over `LANES`) is added to `acc`.
  - `acc` width is `DATA_W + log2(VEC_LEN) + 1`, so it never overflows.
  - `beat_cnt` increments.
- Final beat is `beat_cnt == BEATS-1`. The counter alone closes the vector; `in_last` is only checked.
- When the final beat is accepted:
  - Go to HOLD.
  - `beat_cnt` returns to 0.
  - Register `mean_out = (acc + beat_sum) >>> log2(VEC_LEN)`. The shift is arithmetic, floor toward −inf. The result always fits `DATA_W`.
- `len_err` pulses for one cycle in the cycle after either mismatch:
  - A beat is accepted with `in_last=1` but it is not the final beat.
  - The final beat is accepted with `in_last=0`.
- HOLD → ACCUM on `out_valid && out_ready`. `acc` clears on that edge.
- Outputs hold stable while `out_valid && !out_ready`.
- `BEATS==1` is legal: every accepted beat is a complete vector.

## Timing
- Reset values:
  - `in_ready=1`, `out_valid=0`, `mean_out=0`, `msq_out=0`, `len_err=0`.
  - `acc=0`, `beat_cnt=0`, state ACCUM.
- Reset mid-vector or in HOLD discards all partial or pending results. There is no output pulse.
- Latency:
  - Final beat accepted at edge t → `out_valid=1` in cycle t+1.
  - Throughput is one vector per `BEATS+1` cycles with `out_ready` held high.
- `in_ready` is low from the cycle after the final beat until the cycle after the output handshake; there is no skid.
- In HOLD, `in_valid` is ignored. A held `in_data` is accepted only once `in_ready` rises.
- `len_err` is registered and coincides with the `out_valid` rise when the final-beat check fails.

## Configuration
- `VEC_MEAN_MSQ_EN` defined:
  - Each lane is squared at `2*DATA_W` bits and shifted `>>> FRAC_W` back to Q format.
  - The squares are summed into `sq_acc` of width `2*DATA_W + log2(VEC_LEN)`.
  - `msq_out = sq_acc >> log2(VEC_LEN)`, saturated to the max positive `DATA_W` value. It is registered with `mean_out` and has the same latency.
- Undefined:
  - No square path and no `msq_out` port.
  - `mean_out` behaviour is identical.

## Test plan
Defaults for all scenarios: `LANES=4`, `VEC_LEN=8`, `out_ready=1` unless stated.
- All lanes 1.0, two beats, `in_last` on beat 2 → `out_valid` the next cycle; `mean_out=1.0`, `msq_out=1.0`, `len_err=0`.
- Elements 0.5, 1.0 … 4.0 → `mean_out=2.25`, `msq_out=6.375`.
- Seven zeros and one −1 LSB → `mean_out` = −1 LSB (floor, not 0); `msq_out=0`.
- `out_ready=0` for 5 cycles after a result:
  - `out_valid` and `mean_out` stay stable.
  - `in_ready=0` throughout.
  - Next vector is accepted only after the handshake.
  - Means of two back-to-back vectors are correct and in order.
- `in_last=1` on beat 1 of 2 → `len_err` pulses one cycle; the vector still completes after beat 2 with the correct mean.
- `reset` asserted after beat 1 → all outputs return to reset values. A following full vector of 2.0 yields `mean_out=2.0` with no contamination.

Source files
------------

// File: rtl/vec_mean_stream.sv
// vec_mean_stream: multi-beat streaming vector mean; define VEC_MEAN_MSQ_EN to add the mean-square output msq_out
module vec_mean_stream #(
    parameter int LANES   = 4,
    parameter int VEC_LEN = 16,
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES-1:0][DATA_W-1:0] in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            mean_out,
`ifdef VEC_MEAN_MSQ_EN
    output logic [DATA_W-1:0]            msq_out,
`endif
    output logic                         len_err
);
    localparam int BEATS = VEC_LEN / LANES;
    localparam int LG    = $clog2(VEC_LEN);
    localparam int AW    = DATA_W + LG + 1;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        beat_cnt;
    logic signed [AW-1:0] acc, beat_sum, acc_nx;
    logic                 accept, final_beat;

    assign accept     = in_valid && in_ready;
    assign final_beat = beat_cnt == CW'(BEATS - 1);
    assign acc_nx     = acc + beat_sum;

    // sign-extended sum of all lanes of the current beat
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++)
            beat_sum = beat_sum + {{(AW-DATA_W){in_data[i][DATA_W-1]}}, in_data[i]};
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= ACCUM;
        else       state <= state_nx;
    end

    // next state and handshake outputs
    always_comb begin
        state_nx  = (state == ACCUM) ? ((accept && final_beat) ? HOLD : ACCUM) : (out_ready ? ACCUM : HOLD);
        in_ready  = state == ACCUM;
        out_valid = state == HOLD;
    end

    // accumulate beats, close the vector on the counter, flag framing mismatches
    always_ff @(posedge clock) begin
        if (reset) begin
            acc      <= '0;
            beat_cnt <= '0;
            mean_out <= '0;
            len_err  <= 1'b0;
        end else begin
            len_err <= accept && (in_last != final_beat);
            if (accept) begin
                acc      <= acc_nx;
                beat_cnt <= final_beat ? '0 : beat_cnt + CW'(1);
                if (final_beat) mean_out <= acc_nx[LG +: DATA_W];
            end else if (out_valid && out_ready) begin
                acc <= '0;
            end
        end
    end

`ifdef VEC_MEAN_MSQ_EN
    localparam int SW = 2*DATA_W + LG;

    logic signed [2*DATA_W-1:0] ex, sq;
    logic [SW-1:0]              sq_acc, sq_sum, sq_nx;
    logic                       sq_ovf;

    assign sq_nx  = sq_acc + sq_sum;
    assign sq_ovf = |sq_nx[SW-1:LG+DATA_W-1];

    // per-lane squares rescaled to Q format, summed; squares are non-negative so zero extension is exact
    always_comb begin
        ex     = '0;
        sq     = '0;
        sq_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            ex     = {{DATA_W{in_data[i][DATA_W-1]}}, in_data[i]};
            sq     = ex * ex;
            sq_sum = sq_sum + ({{LG{1'b0}}, sq} >> FRAC_W);
        end
    end

    // square accumulator and saturated mean-square result
    always_ff @(posedge clock) begin
        if (reset) begin
            sq_acc  <= '0;
            msq_out <= '0;
        end else if (accept) begin
            sq_acc <= sq_nx;
            if (final_beat) msq_out <= sq_ovf ? {1'b0, {(DATA_W-1){1'b1}}} : {1'b0, sq_nx[LG+DATA_W-2:LG]};
        end else if (out_valid && out_ready) begin
            sq_acc <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_vec_mean_stream.sv
// tb_vec_mean_stream: directed and randomized checks of vec_mean_stream against an arithmetic reference
module tb_vec_mean_stream;
    localparam int LANES = 4;
    localparam int VL    = 8;
    localparam int DW    = 16;
    localparam int FW    = 8;

    logic clock = 1'b0;
    logic reset, in_valid, in_ready, in_last, out_valid, out_ready, len_err;
    logic [LANES-1:0][DW-1:0] in_data;
    logic [DW-1:0] mean_out;
`ifdef VEC_MEAN_MSQ_EN
    logic [DW-1:0] msq_out;
`endif
    int checks = 0;
    int errors = 0;

    vec_mean_stream #(.LANES(LANES), .VEC_LEN(VL), .DATA_W(DW), .FRAC_W(FW)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mean_out(mean_out),
`ifdef VEC_MEAN_MSQ_EN
        .msq_out(msq_out),
`endif
        .len_err(len_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic int ref_mean(input int v[VL]);
        int s = 0;
        foreach (v[i]) s += v[i];
        return s >>> $clog2(VL);
    endfunction

    function automatic int ref_msq(input int v[VL]);
        int s = 0;
        foreach (v[i]) s += (v[i] * v[i]) >>> FW;
        s = s / VL;
        return (s > 32767) ? 32767 : s;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_beat(input int v[VL], input int b, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_last  = last;
        for (int j = 0; j < LANES; j++) in_data[j] = DW'(v[b*LANES+j]);
        while (!in_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("beat_ready", {15'b0, in_ready}, 16'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_vec(input int v[VL], input logic l0, input logic l1);
        drive_beat(v, 0, l0);
        drive_beat(v, 1, l1);
    endtask

    task automatic check_result(input string tag, input int v[VL], input logic lerr);
        chk({tag, "_valid"}, {15'b0, out_valid}, 16'd1);
        chk({tag, "_ready"}, {15'b0, in_ready}, 16'd0);
        chk({tag, "_mean"}, mean_out, DW'(ref_mean(v)));
        chk({tag, "_lenerr"}, {15'b0, len_err}, {15'b0, lerr});
`ifdef VEC_MEAN_MSQ_EN
        chk({tag, "_msq"}, msq_out, DW'(ref_msq(v)));
`endif
    endtask

    task automatic drain(input string tag);
        @(posedge clock); #1;
        chk({tag, "_drain_valid"}, {15'b0, out_valid}, 16'd0);
        chk({tag, "_drain_lenerr"}, {15'b0, len_err}, 16'd0);
    endtask

    initial begin
        int v[VL];
        int w[VL];
        int r;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        reset     = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_in_ready", {15'b0, in_ready}, 16'd1);
        chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
        chk("rst_mean", mean_out, 16'd0);
        chk("rst_len_err", {15'b0, len_err}, 16'd0);
`ifdef VEC_MEAN_MSQ_EN
        chk("rst_msq", msq_out, 16'd0);
`endif
        foreach (v[i]) v[i] = 256;
        drive_beat(v, 0, 1'b0);
        chk("ones_mid_valid", {15'b0, out_valid}, 16'd0);
        chk("ones_mid_ready", {15'b0, in_ready}, 16'd1);
        drive_beat(v, 1, 1'b1);
        check_result("ones", v, 1'b0);
        chk("ones_const", mean_out, 16'd256);
        drain("ones");
        foreach (v[i]) v[i] = 128 * (i + 1);
        send_vec(v, 1'b0, 1'b1);
        check_result("ramp", v, 1'b0);
        chk("ramp_const", mean_out, 16'd576);
`ifdef VEC_MEAN_MSQ_EN
        chk("ramp_msq_const", msq_out, 16'd1632);
`endif
        drain("ramp");
        foreach (v[i]) v[i] = 0;
        v[7] = -1;
        send_vec(v, 1'b0, 1'b1);
        check_result("neg_lsb", v, 1'b0);
        chk("neg_lsb_const", mean_out, 16'hffff);
        drain("neg_lsb");
        foreach (v[i]) v[i] = $urandom_range(0, 2000) - 1000;
        foreach (w[i]) w[i] = $urandom_range(0, 2000) - 1000;
        out_ready = 1'b0;
        send_vec(v, 1'b0, 1'b1);
        check_result("bp_a", v, 1'b0);
        in_valid = 1'b1;
        for (int j = 0; j < LANES; j++) in_data[j] = DW'(w[j]);
        repeat (5) begin
            @(posedge clock); #1;
            chk("bp_hold_valid", {15'b0, out_valid}, 16'd1);
            chk("bp_hold_mean", mean_out, DW'(ref_mean(v)));
            chk("bp_hold_ready", {15'b0, in_ready}, 16'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_release_valid", {15'b0, out_valid}, 16'd0);
        chk("bp_release_ready", {15'b0, in_ready}, 16'd1);
        send_vec(w, 1'b0, 1'b1);
        check_result("bp_b", w, 1'b0);
        drain("bp_b");
        foreach (v[i]) v[i] = $urandom_range(0, 4000) - 2000;
        drive_beat(v, 0, 1'b1);
        chk("early_last_pulse", {15'b0, len_err}, 16'd1);
        chk("early_last_valid", {15'b0, out_valid}, 16'd0);
        @(posedge clock); #1;
        chk("early_last_clear", {15'b0, len_err}, 16'd0);
        drive_beat(v, 1, 1'b1);
        check_result("early_last", v, 1'b0);
        drain("early_last");
        foreach (w[i]) w[i] = $urandom_range(0, 4000) - 2000;
        send_vec(w, 1'b0, 1'b0);
        check_result("missing_last", w, 1'b1);
        drain("missing_last");
        foreach (v[i]) v[i] = $urandom_range(0, 30000) - 15000;
        drive_beat(v, 0, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midrst_in_ready", {15'b0, in_ready}, 16'd1);
        chk("midrst_out_valid", {15'b0, out_valid}, 16'd0);
        chk("midrst_mean", mean_out, 16'd0);
        chk("midrst_len_err", {15'b0, len_err}, 16'd0);
`ifdef VEC_MEAN_MSQ_EN
        chk("midrst_msq", msq_out, 16'd0);
`endif
        foreach (v[i]) v[i] = 512;
        send_vec(v, 1'b0, 1'b1);
        check_result("post_rst", v, 1'b0);
        chk("post_rst_const", mean_out, 16'd512);
        drain("post_rst");
        for (int k = 0; k < 24; k++) begin
            foreach (v[i]) v[i] = (k % 2) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 1200)) - 600;
            out_ready = 1'b0;
            send_vec(v, 1'b0, 1'b1);
            check_result("rand", v, 1'b0);
            r = $urandom_range(0, 3);
            repeat (r) begin
                @(posedge clock); #1;
                chk("rand_hold_valid", {15'b0, out_valid}, 16'd1);
                chk("rand_hold_mean", mean_out, DW'(ref_mean(v)));
            end
            out_ready = 1'b1;
            drain("rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
